// File: rtl/dual_port_latency_memory.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_latency_memory
// Purpose  : Word memory with a read-only port and a read/write port, each
//            served by its own fixed-latency IDLE/WAIT/DONE controller.
// Revision : 1.0
// ============================================================================
module dual_port_latency_memory #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  // Port 1: read only
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  output logic                 M1busy,
  // Port 2: read/write over a shared data bus
  input  logic                 readM2,
  input  logic                 writeM2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic                 M2busy
);

  localparam int         DEPTH      = 2 ** ADDR_BITS;
  localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         c_SINGLE   = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Port 1 controller
  // --------------------------------------------------------------------------
  state_t               r_state1;
  state_t               w_next1;
  logic [3:0]           r_cnt1;
  logic [ADDR_BITS-1:0] r_addr1;
  logic [ADDR_BITS-1:0] w_idx1;
  logic [ADDR_BITS-1:0] w_acc_idx1;
  logic [WORD_SIZE-1:0] r_data1;
  logic                 w_enter_done1;

  assign w_idx1        = address1[ADDR_BITS-1:0];
  // With single-cycle latency DONE is entered straight from IDLE, so the live
  // address is used instead of the not-yet-latched copy.
  assign w_acc_idx1    = (r_state1 == S_IDLE) ? w_idx1 : r_addr1;
  assign w_enter_done1 = (w_next1 == S_DONE) && (r_state1 != S_DONE);
  assign data1         = r_data1;

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_state1 <= S_IDLE;
    end else begin
      r_state1 <= w_next1;
    end
  end

  always_comb begin
    w_next1 = r_state1;
    M1busy  = 1'b0;
    case (r_state1)
      S_IDLE: begin
        M1busy = readM1;
        if (readM1) begin
          w_next1 = c_SINGLE ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        M1busy = 1'b1;
        if (r_cnt1 == 4'd1) begin
          w_next1 = S_DONE;
        end
      end
      S_DONE: begin
        w_next1 = S_IDLE;
      end
      default: begin
        w_next1 = S_IDLE;
      end
    endcase
    if (!Reset_N) begin
      M1busy = readM1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_cnt1  <= '0;
      r_addr1 <= '0;
      r_data1 <= '0;
    end else begin
      if ((r_state1 == S_IDLE) && readM1) begin
        r_addr1 <= w_idx1;
        r_cnt1  <= c_CNT_LOAD;
      end else if (r_state1 == S_WAIT) begin
        r_cnt1  <= r_cnt1 - 4'd1;
      end
      if (w_enter_done1) begin
        r_data1 <= r_mem[w_acc_idx1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Port 2 controller
  // --------------------------------------------------------------------------
  state_t               r_state2;
  state_t               w_next2;
  logic [3:0]           r_cnt2;
  logic [ADDR_BITS-1:0] r_addr2;
  logic                 r_wr2;
  logic [WORD_SIZE-1:0] r_wdata2;
  logic [WORD_SIZE-1:0] r_rdata2;
  logic                 w_req2;
  logic [ADDR_BITS-1:0] w_idx2;
  logic [ADDR_BITS-1:0] w_acc_idx2;
  logic                 w_acc_wr2;
  logic [WORD_SIZE-1:0] w_acc_wdata2;
  logic                 w_enter_done2;
  logic                 w_drive2;

  assign w_req2        = readM2 | writeM2;
  assign w_idx2        = address2[ADDR_BITS-1:0];
  assign w_acc_idx2    = (r_state2 == S_IDLE) ? w_idx2   : r_addr2;
  // Write wins when both request lines are raised together.
  assign w_acc_wr2     = (r_state2 == S_IDLE) ? writeM2  : r_wr2;
  assign w_acc_wdata2  = (r_state2 == S_IDLE) ? data2    : r_wdata2;
  assign w_enter_done2 = (w_next2 == S_DONE) && (r_state2 != S_DONE);
  assign w_drive2      = Reset_N && (r_state2 == S_DONE) && !r_wr2;
  assign data2         = w_drive2 ? r_rdata2 : {WORD_SIZE{1'bz}};

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_state2 <= S_IDLE;
    end else begin
      r_state2 <= w_next2;
    end
  end

  always_comb begin
    w_next2 = r_state2;
    M2busy  = 1'b0;
    case (r_state2)
      S_IDLE: begin
        M2busy = w_req2;
        if (w_req2) begin
          w_next2 = c_SINGLE ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        M2busy = 1'b1;
        if (r_cnt2 == 4'd1) begin
          w_next2 = S_DONE;
        end
      end
      S_DONE: begin
        w_next2 = S_IDLE;
      end
      default: begin
        w_next2 = S_IDLE;
      end
    endcase
    if (!Reset_N) begin
      M2busy = w_req2;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      r_cnt2   <= '0;
      r_addr2  <= '0;
      r_wr2    <= 1'b0;
      r_wdata2 <= '0;
      r_rdata2 <= '0;
    end else begin
      if ((r_state2 == S_IDLE) && w_req2) begin
        r_addr2  <= w_idx2;
        r_wr2    <= writeM2;
        r_wdata2 <= data2;
        r_cnt2   <= c_CNT_LOAD;
      end else if (r_state2 == S_WAIT) begin
        r_cnt2   <= r_cnt2 - 4'd1;
      end
      if (w_enter_done2 && !w_acc_wr2) begin
        r_rdata2 <= r_mem[w_acc_idx2];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage: never cleared; a reset edge suppresses any pending commit.
  // Port 1 samples with non-blocking semantics, so a same-edge port-2 commit
  // is seen by port 1 as the old word.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset_N && w_enter_done2 && w_acc_wr2) begin
      r_mem[w_acc_idx2] <= w_acc_wdata2;
    end
  end

  generate
    if (ADDR_BITS < WORD_SIZE) begin : g_unused_addr
      wire w_unused_hi = ^{address1[WORD_SIZE-1:ADDR_BITS],
                           address2[WORD_SIZE-1:ADDR_BITS]};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dual_port_latency_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_latency_memory
// Purpose  : Self-checking bench for dual_port_latency_memory (LATENCY 4 and 1).
// Revision : 1.0
// ============================================================================
module tb_dual_port_latency_memory;

  localparam int LAT = 4;

  typedef struct {
    bit          p2;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        readM1;
  logic [15:0] address1;
  logic [15:0] data1;
  logic        M1busy;
  logic        readM2;
  logic        writeM2;
  logic [15:0] address2;
  wire  [15:0] data2;
  logic        M2busy;
  logic        tb_d2_en;
  logic [15:0] tb_d2;

  // Second instance with single-cycle latency
  logic        l1_read1;
  logic [15:0] l1_addr1;
  logic [15:0] l1_data1;
  logic        l1_busy1;
  logic        l1_read2;
  logic        l1_write2;
  logic [15:0] l1_addr2;
  wire  [15:0] data2_l1;
  logic        l1_busy2;
  logic [15:0] l1_d2;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  vec_t        vecs[13];

  // The bench drives data2 to 0 whenever the DUT must be released; a DUT that
  // drives in those cycles corrupts the value seen on the bus.
  assign data2    = tb_d2_en ? tb_d2 : 16'hzzzz;
  assign data2_l1 = l1_write2 ? l1_d2 : 16'h0000;

  always #5 Clk = ~Clk;

  dual_port_latency_memory #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT)) dut (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .readM1   (readM1),
    .address1 (address1),
    .data1    (data1),
    .M1busy   (M1busy),
    .readM2   (readM2),
    .writeM2  (writeM2),
    .address2 (address2),
    .data2    (data2),
    .M2busy   (M2busy)
  );

  dual_port_latency_memory #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) dut_l1 (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .readM1   (l1_read1),
    .address1 (l1_addr1),
    .data1    (l1_data1),
    .M1busy   (l1_busy1),
    .readM2   (l1_read2),
    .writeM2  (l1_write2),
    .address2 (l1_addr2),
    .data2    (data2_l1),
    .M2busy   (l1_busy2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Runs one access starting just after a rising edge; ends just after the
  // rising edge that follows the idle cycle after DONE.
  task automatic run_access(input vec_t v, input int id);
    logic [15:0] want;
    string       tag;
    tag = $sformatf("vec%0d", id);
    if (!v.p2) begin
      readM1   = 1'b1;
      address1 = v.addr;
      q1.push_back(v.exp);
    end else begin
      address2 = v.addr;
      if (v.wr) begin
        writeM2 = 1'b1;
        tb_d2   = v.wdata;
      end else begin
        readM2 = 1'b1;
        q2.push_back(v.exp);
      end
    end
    for (int c = 0; c <= LAT; c++) begin
      if (c > 0) begin
        next_cycle();
        address1 = ~v.addr;
        address2 = ~v.addr;
        tb_d2    = 16'h0000;
        if (v.p2 && !v.wr && (c == LAT)) tb_d2_en = 1'b0;
      end
      @(negedge Clk);
      check({tag, " busy"}, 32'(v.p2 ? M2busy : M1busy), 32'(c < LAT));
      if (v.p2 && (c > 0) && !((c == LAT) && !v.wr))
        check({tag, " data2 released"}, 32'(data2), 32'h0);
      if (c == LAT) begin
        if (!v.p2) begin
          if (q1.size() == 0) check({tag, " q1 empty"}, 32'h1, 32'h0);
          else begin
            want = q1.pop_front();
            check({tag, " data1"}, 32'(data1), 32'(want));
          end
        end else if (!v.wr) begin
          if (q2.size() == 0) check({tag, " q2 empty"}, 32'h1, 32'h0);
          else begin
            want = q2.pop_front();
            check({tag, " data2"}, 32'(data2), 32'(want));
          end
        end
      end
    end
    next_cycle();
    readM1   = 1'b0;
    readM2   = 1'b0;
    writeM2  = 1'b0;
    tb_d2_en = 1'b1;
    tb_d2    = 16'h0000;
    @(negedge Clk);
    if (!v.p2) check({tag, " data1 hold"}, 32'(data1), 32'(v.exp));
    else       check({tag, " data2 idle"}, 32'(data2), 32'h0);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad_cnt);
    $fatal(1);
  end

  initial begin
    logic exp_busy[6];
    vec_t tmp;

    vecs[0]  = '{1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 16'h0005, 16'h0555, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 16'h0006, 16'h0666, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 16'h0030, 16'h0001, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 16'h0040, 16'h4040, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
    vecs[7]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF};
    vecs[8]  = '{1'b1, 1'b0, 16'h0105, 16'h0000, 16'h0555};
    vecs[9]  = '{1'b0, 1'b0, 16'hFF06, 16'h0000, 16'h0666};
    vecs[10] = '{1'b1, 1'b1, 16'h01FF, 16'hCAFE, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hCAFE};
    vecs[12] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h4040};

    Reset_N   = 1'b0;
    readM1    = 1'b1;
    readM2    = 1'b0;
    writeM2   = 1'b0;
    address1  = 16'h0000;
    address2  = 16'h0000;
    tb_d2_en  = 1'b1;
    tb_d2     = 16'h0000;
    l1_read1  = 1'b0;
    l1_addr1  = 16'h0000;
    l1_read2  = 1'b0;
    l1_write2 = 1'b0;
    l1_addr2  = 16'h0000;
    l1_d2     = 16'h0000;

    // Reset: busy follows the request, storage outputs are cleared
    @(negedge Clk);
    check("reset M1busy follows req", 32'(M1busy), 32'h1);
    check("reset M2busy", 32'(M2busy), 32'h0);
    next_cycle();
    readM1 = 1'b0;
    next_cycle();
    @(negedge Clk);
    check("reset M1busy idle", 32'(M1busy), 32'h0);
    check("reset data1", 32'(data1), 32'h0);
    check("reset data2 released", 32'(data2), 32'h0);
    next_cycle();
    Reset_N = 1'b1;
    @(negedge Clk);
    check("post-reset M1busy", 32'(M1busy), 32'h0);
    check("post-reset M2busy", 32'(M2busy), 32'h0);
    next_cycle();

    foreach (vecs[i]) run_access(vecs[i], i);

    // Held port-1 read: re-accepted immediately after DONE
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    readM1   = 1'b1;
    address1 = 16'h0010;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      @(negedge Clk);
      check($sformatf("held busy c%0d", c), 32'(M1busy), 32'(exp_busy[c]));
      if (c == 4) check("held data1", 32'(data1), 32'h1234);
    end
    next_cycle();
    readM1 = 1'b0;
    repeat (LAT) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("dropped read completes idle", 32'(M1busy), 32'h0);
    check("dropped read data1", 32'(data1), 32'h1234);
    next_cycle();

    // Same-edge collision at 0x30, port 2 raises both read and write
    readM1   = 1'b1;
    address1 = 16'h0030;
    readM2   = 1'b1;
    writeM2  = 1'b1;
    address2 = 16'h0030;
    tb_d2    = 16'h0002;
    for (int c = 0; c <= LAT; c++) begin
      if (c > 0) begin
        next_cycle();
        tb_d2 = 16'h0000;
      end
      @(negedge Clk);
    end
    check("collision old value", 32'(data1), 32'h0001);
    check("collision M2busy done", 32'(M2busy), 32'h0);
    check("read+write is write", 32'(data2), 32'h0);
    next_cycle();
    readM1  = 1'b0;
    readM2  = 1'b0;
    writeM2 = 1'b0;
    next_cycle();
    tmp = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0002};
    run_access(tmp, 100);
    tmp = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0002};
    run_access(tmp, 101);

    // Reset during the WAIT of a write must leave storage untouched
    writeM2  = 1'b1;
    address2 = 16'h0040;
    tb_d2    = 16'hAAAA;
    next_cycle();
    writeM2  = 1'b0;
    tb_d2    = 16'h0000;
    next_cycle();
    Reset_N  = 1'b0;
    @(negedge Clk);
    check("mid reset M2busy", 32'(M2busy), 32'h0);
    check("mid reset data2 released", 32'(data2), 32'h0);
    next_cycle();
    Reset_N  = 1'b1;
    @(negedge Clk);
    check("abort data1 cleared", 32'(data1), 32'h0);
    check("abort M1busy", 32'(M1busy), 32'h0);
    check("abort M2busy", 32'(M2busy), 32'h0);
    next_cycle();
    tmp = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h4040};
    run_access(tmp, 200);
    tmp = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h4040};
    run_access(tmp, 201);

    // Single-cycle latency instance
    l1_write2 = 1'b1;
    l1_addr2  = 16'h0007;
    l1_d2     = 16'h7777;
    @(negedge Clk);
    check("L1 write busy", 32'(l1_busy2), 32'h1);
    next_cycle();
    l1_write2 = 1'b0;
    @(negedge Clk);
    check("L1 write done busy", 32'(l1_busy2), 32'h0);
    next_cycle();
    l1_write2 = 1'b1;
    l1_addr2  = 16'h0008;
    l1_d2     = 16'h8888;
    next_cycle();
    l1_write2 = 1'b0;
    next_cycle();
    l1_read1  = 1'b1;
    l1_addr1  = 16'h0007;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      if (c == 1) l1_addr1 = 16'h0008;
      @(negedge Clk);
      check($sformatf("L1 busy c%0d", c), 32'(l1_busy1), 32'(c % 2 == 0));
      if (c == 1) check("L1 data first", 32'(l1_data1), 32'h7777);
      if (c == 3) check("L1 data second", 32'(l1_data1), 32'h8888);
    end
    next_cycle();
    l1_read1 = 1'b0;
    @(negedge Clk);
    check("L1 idle after drop", 32'(l1_busy1), 32'h0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dual_port_latency_memory.md
DUAL_PORT_LATENCY_MEMORY -- requirements
Module: dual_port_latency_memory

Interface
REQ-001 SHALL have parameter WORD_SIZE, 16, data and address width.
REQ-002 SHALL have parameter ADDR_BITS, 8, number of address LSBs used to index storage (depth 2^ADDR_BITS).
REQ-003 SHALL have parameter LATENCY, 4, cycles from request to data valid; legal range 1..15.
REQ-004 SHALL have ports: Clk  in  1  clock, rising edge; Reset_N  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: readM1  in  1  port-1 read request; address1  in  WORD_SIZE  port-1 address; data1  out  WORD_SIZE  port-1 read data; M1busy  out  1  port-1 stall.
REQ-006 SHALL have ports: readM2  in  1  port-2 read request; writeM2  in  1  port-2 write request; address2  in  WORD_SIZE  port-2 address; data2  inout  WORD_SIZE  port-2 bidirectional data; M2busy  out  1  port-2 stall.

Function
REQ-007 SHALL hold 2^ADDR_BITS words; an address selects word address[ADDR_BITS-1:0], with upper bits ignored so addresses wrap.
REQ-008 SHALL run one independent FSM per port, with states IDLE, WAIT and DONE.
REQ-009 In IDLE, the FSM SHALL drive busy combinationally equal to the port's request (readM1, or readM2|writeM2).
REQ-010 In IDLE, on an edge with a request, the FSM SHALL latch the address (port 2 also latches op and data2 for writes), load counter LATENCY-1, and go to WAIT, or to DONE if LATENCY==1.
REQ-011 In WAIT, busy SHALL be 1 and the counter SHALL decrement each edge; on the edge where the counter==1 the FSM SHALL go to DONE.
REQ-012 On entry to DONE: a read SHALL load the output register from storage; a write SHALL commit the latched data to storage.
REQ-013 In DONE, busy SHALL be 0 and the FSM SHALL return to IDLE on the next edge; the requester samples data on that edge.
REQ-014 Timing: request first presented in cycle N gives busy=1 in cycles N..N+LATENCY-1 and busy=0 with data valid in cycle N+LATENCY.
REQ-015 Minimum spacing between accepted requests on one port SHALL be LATENCY+1 cycles, because IDLE always re-asserts busy for a held request.
REQ-016 data1 SHALL hold the last completed port-1 read value until the next port-1 completion.
REQ-017 data2 SHALL be driven with the read value only when state2==DONE and the latched op is read; otherwise data2 SHALL be high-Z.
REQ-018 Address, request or data changes after acceptance SHALL be ignored; an access in flight cannot be aborted except by reset.
REQ-019 A dropped request SHALL still run to DONE, and the result SHALL be discarded.
REQ-020 If readM2 and writeM2 are both 1 at acceptance, the access SHALL be a write.
REQ-021 Same-word collision SHALL be read-before-write: when port-1 DONE-entry and port-2 write commit fall on the same edge, port 1 returns the old value.
REQ-022 Storage contents SHALL be preloadable by the testbench through hierarchical access or an initial block.

Reset
REQ-023 While Reset_N==0 at an edge, both FSMs SHALL go to IDLE, counters SHALL be 0 and data1 register SHALL be 0.
REQ-024 During reset, M1busy and M2busy SHALL follow REQ-009 and data2 SHALL be high-Z.
REQ-025 Reset asserted mid-access SHALL abort the access, discard any pending write and leave storage unchanged.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-027 LATENCY=4, mem[0x10]=0x1234; readM1=1, address1=0x0010 held from cycle 0 -> M1busy=1 cycles 0-3, M1busy=0 and data1=0x1234 in cycle 4, M1busy=1 again in cycle 5.
REQ-028 writeM2=1, address2=0x0020, data2=0xBEEF for one cycle, then readM2=1 at 0x0020 after completion -> read returns 0xBEEF on data2 in its DONE cycle; data2 is Z in all other cycles.
REQ-029 Port-1 read and port-2 write to 0x30 (old 0x0001, new 0x0002) accepted on the same edge -> port 1 returns 0x0001, and a later read returns 0x0002.
REQ-030 Accept port-2 read at 0x05, change address2 to 0x06 during WAIT -> returns mem[0x05]; address 0x0105 with ADDR_BITS=8 -> returns mem[0x05].
REQ-031 Reset_N=0 for one cycle during WAIT of a write of 0xAAAA to 0x40 -> mem[0x40] is unchanged, both ports are IDLE, and data1 = 0.
REQ-032 LATENCY=1 back-to-back port-1 reads -> busy pattern 1,0,1,0 with data valid in each busy=0 cycle.
